// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the player-button front end and the LED-matrix
//   control FSM that consumes its events.
//   - EVT_*  : 2-bit event codes carried on evt_code (EVT_NONE never valid)
//   - BTN_*  : bit index of each button inside 3-bit button vectors
// -----------------------------------------------------------------------------
package button_pkg;

  localparam logic [1:0] EVT_NONE   = 2'd0;
  localparam logic [1:0] EVT_RED    = 2'd1;
  localparam logic [1:0] EVT_BLUE   = 2'd2;
  localparam logic [1:0] EVT_YELLOW = 2'd3;

  localparam int BTN_RED    = 0;
  localparam int BTN_BLUE   = 1;
  localparam int BTN_YELLOW = 2;
  localparam int NUM_BTN    = 3;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One raw button: 2-FF synchronizer, level debounce filter, press pulse.
//   Ports:
//     clk, rst : system clock, synchronous active-high reset
//     raw      : asynchronous button input, 1 = pressed
//     level    : debounced (stable) level
//     press    : 1-cycle pulse, high in the cycle whose closing edge moves
//                level from 0 to 1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new level has now been seen for DEBOUNCE_CYCLES consecutive edges.
  assign accept = (sync_p1 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      // stage p0 -> p1: metastability synchronizer
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p1 -> stable: debounce filter, sees only the synchronized level
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign press = accept && sync_p1;

endmodule

// File: rtl/button_event_queue.sv
// -----------------------------------------------------------------------------
// button_event_queue
//   Debounces the red/blue/yellow buttons and queues one event per press for
//   the LED-matrix control FSM. A press that cannot enter the FIFO waits in a
//   per-button pending bit; a second press on a button whose pending bit is
//   still set is merged and counted in drop_cnt.
//   Ports:
//     clk, rst       : 100 MHz clock, synchronous active-high reset
//     red_button     : raw button inputs, 1 = pressed
//     blue_button
//     yellow_button
//     btn_level[2:0] : debounced levels {yellow, blue, red}
//     evt_valid      : FIFO head holds an event
//     evt_code[1:0]  : head event code (EVT_RED/EVT_BLUE/EVT_YELLOW)
//     evt_ready      : consumer accepts head; pop on evt_valid && evt_ready
//     drop_cnt[7:0]  : saturating count of merged presses
// -----------------------------------------------------------------------------
module button_event_queue
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_button,
  input  logic       blue_button,
  input  logic       yellow_button,
  output logic [2:0] btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic [7:0] drop_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] push_mask;
  logic [NUM_BTN-1:0] drop_hits;
  logic [1:0]         push_code;
  logic [1:0]         drop_inc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [1:0]         mem [FIFO_DEPTH];
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign raw[BTN_RED]    = red_button;
  assign raw[BTN_BLUE]   = blue_button;
  assign raw[BTN_YELLOW] = yellow_button;

  // stage in -> level/press: per-button conditioning
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign btn_level = level;

  // stage level/press -> pending -> FIFO: priority select, red first
  always_comb begin
    push_mask = '0;
    push_code = EVT_NONE;
    if (pending[BTN_RED]) begin
      push_mask[BTN_RED] = 1'b1;
      push_code          = EVT_RED;
    end else if (pending[BTN_BLUE]) begin
      push_mask[BTN_BLUE] = 1'b1;
      push_code           = EVT_BLUE;
    end else if (pending[BTN_YELLOW]) begin
      push_mask[BTN_YELLOW] = 1'b1;
      push_code             = EVT_YELLOW;
    end
  end

  // Full and empty differ only in the wrap bit of the pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && evt_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push  = (|pending) && (!full || pop);

  assign drop_hits = press & pending;
  assign drop_inc  = {1'b0, drop_hits[0]} + {1'b0, drop_hits[1]} + {1'b0, drop_hits[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      // A new press re-arms its bit even if the old one is pushed this cycle.
      pending  <= (pending & ~(push ? push_mask : '0)) | press;
      drop_cnt <= sat_add8(drop_cnt, drop_inc);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  // stage FIFO -> consumer: registered head, no bypass
  assign evt_valid = !empty;
  assign evt_code  = empty ? EVT_NONE : mem[rd_ptr[AW-1:0]];

endmodule
